// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Iterative RV32M multiply/divide unit placed beside the execute
//            ALU. One shift-add (multiply) or restoring-divide step per
//            cycle; stalls the front of the pipeline until the result is
//            ready, then presents it for exactly one cycle.
// Ports    : clk      - core clock, rising edge
//            rstN     - asynchronous active-low reset
//            start    - execute stage holds a valid M-extension op
//            flush    - execute-stage flush, cancels any op in flight
//            funct3   - 000 MUL .. 111 REMU
//            srcA     - rs1 after forwarding
//            srcB     - rs2 after forwarding
//            stallReq - hold fetch/decode/execute pipeline registers
//            done     - result valid this cycle
//            result   - rd value, valid when done=1
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            stallReq,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              c_CNT_W   = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [2:0]            r_fn;
  logic                  r_sa;      // srcA was signed and negative
  logic                  r_sb;      // srcB was signed and negative
  logic                  r_fast;    // result came from the fast path, no fix-up
  logic [XLEN-1:0]       r_a;       // multiplier / dividend, becomes quotient
  logic [XLEN-1:0]       r_b;       // multiplicand / divisor
  logic [2*XLEN-1:0]     r_acc;     // product; high half doubles as remainder
  logic [c_CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]       r_last;    // last presented result, held outside DONE

  // ---------------- operand decode at acceptance ----------------
  logic            w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_div0, w_ovf, w_accept;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU leaves rs2 unsigned.
  assign w_sgn_a  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sgn_b  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_neg_a  = w_sgn_a & srcA[XLEN-1];
  assign w_neg_b  = w_sgn_b & srcB[XLEN-1];
  assign w_abs_a  = w_neg_a ? (-srcA) : srcA;
  assign w_abs_b  = w_neg_b ? (-srcB) : srcB;
  assign w_div0   = funct3[2] && (srcB == '0);
  assign w_ovf    = funct3[2] && !funct3[0] && (srcA == c_MIN_NEG) && (srcB == '1);
  assign w_accept = (r_state == S_IDLE) && start && !flush;

  // ---------------- one iteration step ----------------
  logic [XLEN:0]   w_msum;   // high half plus optional multiplicand, with carry
  logic [XLEN:0]   w_shl;    // partial remainder shifted left with next dividend bit
  logic [XLEN:0]   w_diff;
  logic            w_borrow;

  assign w_msum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_a[0] ? r_b : {XLEN{1'b0}})};
  assign w_shl    = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
  assign w_diff   = w_shl - {1'b0, r_b};
  // Partial remainder is always below 2*divisor, so bit XLEN of the
  // difference is set exactly when the trial subtraction borrows.
  assign w_borrow = w_diff[XLEN];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_fn    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_fast  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fn  <= funct3;
            r_sa  <= w_neg_a;
            r_sb  <= w_neg_b;
            r_b   <= w_abs_b;
            r_cnt <= '0;
            if (w_div0) begin
              r_fast  <= 1'b1;
              r_a     <= '1;
              r_acc   <= {srcA, {XLEN{1'b0}}};
              r_state <= S_DONE;
            end else if (w_ovf) begin
              r_fast  <= 1'b1;
              r_a     <= c_MIN_NEG;
              r_acc   <= '0;
              r_state <= S_DONE;
            end else begin
              r_fast  <= 1'b0;
              r_a     <= w_abs_a;
              r_acc   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_fn[2]) begin
              r_acc[2*XLEN-1:XLEN] <= w_borrow ? w_shl[XLEN-1:0] : w_diff[XLEN-1:0];
              r_a                  <= {r_a[XLEN-2:0], ~w_borrow};
            end else begin
              r_acc <= {w_msum, r_acc[XLEN-1:1]};
              r_a   <= r_a >> 1;
            end
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (r_cnt == c_LAST) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_last  <= result;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- sign fix-up and result select ----------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_fix;

  assign w_prod = (r_sa ^ r_sb) ? (-r_acc) : r_acc;
  assign w_quot = (r_sa ^ r_sb) ? (-r_a) : r_a;
  assign w_rem  = r_sa ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix = '0;
    case (r_fn)
      3'b000:                 w_fix = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix = r_fast ? r_a : w_quot;
      default:                w_fix = r_fast ? r_acc[2*XLEN-1:XLEN] : w_rem;
    endcase
  end

  assign done   = (r_state == S_DONE);
  assign result = done ? w_fix : r_last;
  // Gated by rstN so a start held during reset cannot raise a stall.
  assign stallReq = rstN && (w_accept || (r_state == S_CALC));

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide unit, bolted beside the execute-stage ALU.
- Sequences one shift-add or restoring-divide step per cycle.
- Holds the execute stage via a stall request until the result is ready, then presents the result for one cycle so it travels down the pipeline like an ALU result.
- Handles divide-by-zero, signed overflow and flush cancellation per the RISC-V M spec.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  core clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- start  in  1  execute stage holds a valid M-extension op (opcode OP, funct7=0000001).
- flush  in  1  execute-stage flush (mispredict); cancels any op in flight.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcA  in  XLEN  rs1 after forwarding.
- srcB  in  XLEN  rs2 after forwarding.
- stallReq  out  1  hold fetch/decode/execute pipeline registers.
- done  out  1  result valid this cycle.
- result  out  XLEN  rd value, valid when done=1.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset: asynchronous on rstN=0.
  - State returns to IDLE; all datapath registers clear.
  - Outputs: stallReq=0, done=0, result=0.
  - Reset mid-operation abandons the op with no done.
- IDLE, start=1 and flush=0 at edge E0:
  - Latch funct3.
  - Latch operand signs: signed for MULH/DIV/REM; srcA only for MULHSU; none for MULHU/DIVU/REMU/MUL.
  - Latch |srcA| and |srcB| per those signs; clear the 2*XLEN accumulator and the counter.
  - Fast path, state goes to DONE at E0, done in cycle E0+1 (latency 1):
    - Divide by zero: quotient=all ones, remainder=srcA.
    - Signed overflow, srcA=0x80000000 and srcB=-1: quotient=0x80000000, remainder=0.
  - Otherwise state goes to CALC.
- CALC: one iteration per edge; counter counts 0..XLEN-1; the edge with counter=XLEN-1 moves to DONE.
  - Multiply: if the multiplier LSB is set, add the multiplicand into the accumulator high half; shift right 1.
  - Divide: restoring. Shift {rem,quot} left 1, trial-subtract the divisor, set the quotient bit when there is no borrow.
- Latency (normal path): start sampled at E0, done=1 in the cycle after edge E0+XLEN, i.e. XLEN+1 cycles after the start cycle (33 for XLEN=32).
- DONE: sign fix-up is combinational from the registered unsigned results.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - MUL returns the low XLEN bits; MULH* returns the high XLEN bits.
  - Fix-up is skipped for fast-path values.
  - done=1 for exactly one cycle; next state is IDLE.
  - start in DONE is not accepted; it is the same instruction leaving.
- stallReq = (IDLE & start & ~flush) | CALC.
  - stallReq=0 in DONE so the pipeline advances in the same cycle done=1.
  - No combinational path from srcA/srcB to stallReq.
- flush: in CALC or DONE it forces IDLE at the next edge with done=0. In IDLE it blocks acceptance of start.
- Simultaneous start and flush in IDLE: flush wins, nothing is latched.
- start while CALC: ignored, since the pipeline is stalled and it is the same instruction.
- Operands are sampled only at E0; changes to srcA/srcB during CALC have no effect.
- result holds its last value outside DONE, but consumers qualify it with done.

Test Plan:
- MUL srcA=7, srcB=0xFFFFFFFD -> done at cycle 33 after start, result=0xFFFFFFEB; stallReq high for cycles 0..32, low at 33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> done one cycle after start, result=0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with latency 1; REM same operands -> 0.
- Start MUL, flush at iteration 10 -> IDLE next edge, no done pulse, stallReq=0. A new DIVU 9/3 issued the next cycle -> 3 after 33 cycles.
- Drive rstN=0 asynchronously mid-CALC -> stallReq, done and result go to 0 immediately, without waiting for a clock edge; after release, a back-to-back MUL 3*4 returns 12.
